// File: rtl/sprite_line_buffer.sv
// Sprite line buffer: composites sprite slices into the back half of a double-buffered scanline RAM.
// Define SPRITE_LINE_ZPRIO_EN to let a higher-z opaque pixel overwrite an existing opaque one.
module sprite_line_buffer #(
    parameter int LINE_WIDTH = 640
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        scanline_start,
    input  logic        line_load,
    input  logic        hFlip,
    input  logic [1:0]  line_z,
    input  logic [4:0]  line_palette,
    input  logic [9:0]  line_addr,
    input  logic        tile_table,
    input  logic [3:0]  tile_x,
    input  logic [3:0]  tile_y_total,
    input  logic [2:0]  tile_y_offset,
    input  logic [2:0]  sizeX,
    input  logic [2:0]  first,
    input  logic [2:0]  last,
    output logic        line_busy,
    output logic        tile_en,
    output logic [11:0] tile_addr,
    input  logic [31:0] tile_data,
    input  logic        pixel_read,
    input  logic [9:0]  pixel_x,
    output logic [8:0]  pixel_color,
    output logic [1:0]  pixel_z,
    output logic        pixel_valid
);
    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WAIT, S_DRAW} state_t;

    state_t      r_state;
    logic        r_wbank;
    logic        r_flip;
    logic [1:0]  r_z;
    logic [4:0]  r_pal;
    logic [9:0]  r_addr;
    logic        r_tbl;
    logic [3:0]  r_tx;
    logic [3:0]  r_ty;
    logic [2:0]  r_yo;
    logic [2:0]  r_sx;
    logic [2:0]  r_last;
    logic [2:0]  r_c;
    logic [2:0]  r_p;
    logic [31:0] r_data;
    logic        r_tile_en;
    logic [11:0] r_tile_addr;
    logic [8:0]  r_color;
    logic [1:0]  r_pz;
    logic        r_pvalid;
    // Entry layout: {opaque, z[1:0], palette[4:0], index[3:0]}
    logic [11:0] r_ram [0:1][0:LINE_WIDTH-1];

    function automatic logic [3:0] src_col(input logic flip, input logic [3:0] tx,
                                           input logic [2:0] sx, input logic [2:0] c);
        if (flip)
            return tx + {1'b0, sx} - {1'b0, c};
        else
            return tx + {1'b0, c};
    endfunction

    logic [10:0] w_x;
    logic [2:0]  w_sp;
    logic [3:0]  w_idx;
    logic        w_in_range;
    logic [9:0]  w_wr_x;
    logic        w_win;
    logic        w_we;
    logic        w_rd_in_range;
    logic [9:0]  w_rd_x;
    logic [11:0] w_rd_entry;

    assign w_x        = {1'b0, r_addr} + {5'b0, r_c, 3'b000} + {8'b0, r_p};
    assign w_sp       = r_flip ? (3'd7 - r_p) : r_p;
    assign w_idx      = r_data[{w_sp, 2'b00} +: 4];
    assign w_in_range = w_x < 11'(LINE_WIDTH);
    assign w_wr_x     = w_in_range ? w_x[9:0] : 10'd0;

`ifdef SPRITE_LINE_ZPRIO_EN
    logic [11:0] w_old;
    assign w_old = r_ram[r_wbank][w_wr_x];
    assign w_win = !w_old[11] || (r_z > w_old[10:9]);
`else
    assign w_win = !r_ram[r_wbank][w_wr_x][11];
`endif

    assign w_we = (r_state == S_DRAW) && (w_idx != 4'd0) && w_in_range && w_win;

    assign w_rd_in_range = {1'b0, pixel_x} < 11'(LINE_WIDTH);
    assign w_rd_x        = w_rd_in_range ? pixel_x : 10'd0;
    assign w_rd_entry    = r_ram[~r_wbank][w_rd_x];

    // Write port owns r_wbank, read/clear port owns the other bank, so they never collide.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < 2; b++)
                for (int i = 0; i < LINE_WIDTH; i++)
                    r_ram[b][i] <= '0;
        end else begin
            if (w_we)
                r_ram[r_wbank][w_wr_x] <= {1'b1, r_z, r_pal, w_idx};
            if (pixel_read && w_rd_in_range)
                r_ram[~r_wbank][w_rd_x] <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_color  <= '0;
            r_pz     <= '0;
            r_pvalid <= 1'b0;
        end else if (pixel_read) begin
            if (w_rd_in_range) begin
                r_color  <= w_rd_entry[8:0];
                r_pz     <= w_rd_entry[10:9];
                r_pvalid <= w_rd_entry[11];
            end else begin
                r_color  <= '0;
                r_pz     <= '0;
                r_pvalid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_wbank     <= 1'b0;
            r_tile_en   <= 1'b0;
            r_tile_addr <= '0;
            r_flip      <= 1'b0;
            r_z         <= '0;
            r_pal       <= '0;
            r_addr      <= '0;
            r_tbl       <= 1'b0;
            r_tx        <= '0;
            r_ty        <= '0;
            r_yo        <= '0;
            r_sx        <= '0;
            r_last      <= '0;
            r_c         <= '0;
            r_p         <= '0;
            r_data      <= '0;
        end else if (scanline_start) begin
            // Swap beats everything, including a load in the same cycle.
            r_state   <= S_IDLE;
            r_wbank   <= ~r_wbank;
            r_tile_en <= 1'b0;
        end else begin
            r_tile_en <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (line_load) begin
                        r_flip <= hFlip;
                        r_z    <= line_z;
                        r_pal  <= line_palette;
                        r_addr <= line_addr;
                        r_tbl  <= tile_table;
                        r_tx   <= tile_x;
                        r_ty   <= tile_y_total;
                        r_yo   <= tile_y_offset;
                        r_sx   <= sizeX;
                        r_last <= last;
                        r_c    <= first;
                        if (first <= last) begin
                            r_state     <= S_FETCH;
                            r_tile_en   <= 1'b1;
                            r_tile_addr <= {tile_table, tile_y_total,
                                            src_col(hFlip, tile_x, sizeX, first), tile_y_offset};
                        end
                    end
                end
                S_FETCH: r_state <= S_WAIT;
                S_WAIT: begin
                    r_data  <= tile_data;
                    r_p     <= 3'd0;
                    r_state <= S_DRAW;
                end
                S_DRAW: begin
                    r_p <= r_p + 3'd1;
                    if (r_p == 3'd7) begin
                        if (r_c == r_last) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_c         <= r_c + 3'd1;
                            r_state     <= S_FETCH;
                            r_tile_en   <= 1'b1;
                            r_tile_addr <= {r_tbl, r_ty, src_col(r_flip, r_tx, r_sx, r_c + 3'd1), r_yo};
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign line_busy   = (r_state != S_IDLE);
    assign tile_en     = r_tile_en;
    assign tile_addr   = r_tile_addr;
    assign pixel_color = r_color;
    assign pixel_z     = r_pz;
    assign pixel_valid = r_pvalid;
endmodule

// File: tb/tb_sprite_line_buffer.sv
// Bench for sprite_line_buffer: directed and random slices checked against a scanline model.
module tb_sprite_line_buffer;
    localparam int LW = 640;
`ifdef SPRITE_LINE_ZPRIO_EN
    localparam bit ZPRIO = 1'b1;
`else
    localparam bit ZPRIO = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        scanline_start = 1'b0;
    logic        line_load = 1'b0;
    logic        hFlip = 1'b0;
    logic [1:0]  line_z = '0;
    logic [4:0]  line_palette = '0;
    logic [9:0]  line_addr = '0;
    logic        tile_table = 1'b0;
    logic [3:0]  tile_x = '0;
    logic [3:0]  tile_y_total = '0;
    logic [2:0]  tile_y_offset = '0;
    logic [2:0]  sizeX = '0;
    logic [2:0]  first = '0;
    logic [2:0]  last = '0;
    logic        line_busy;
    logic        tile_en;
    logic [11:0] tile_addr;
    logic [31:0] tile_data = '0;
    logic        pixel_read = 1'b0;
    logic [9:0]  pixel_x = '0;
    logic [8:0]  pixel_color;
    logic [1:0]  pixel_z;
    logic        pixel_valid;

    sprite_line_buffer #(.LINE_WIDTH(LW)) dut (
        .clk(clk), .rst(rst), .scanline_start(scanline_start), .line_load(line_load),
        .hFlip(hFlip), .line_z(line_z), .line_palette(line_palette), .line_addr(line_addr),
        .tile_table(tile_table), .tile_x(tile_x), .tile_y_total(tile_y_total),
        .tile_y_offset(tile_y_offset), .sizeX(sizeX), .first(first), .last(last),
        .line_busy(line_busy), .tile_en(tile_en), .tile_addr(tile_addr), .tile_data(tile_data),
        .pixel_read(pixel_read), .pixel_x(pixel_x), .pixel_color(pixel_color),
        .pixel_z(pixel_z), .pixel_valid(pixel_valid)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [9:0] addr;
        logic [2:0] first;
        logic [2:0] last;
        logic       flip;
        logic [2:0] sx;
        logic [1:0] z;
        logic [4:0] pal;
        logic       tbl;
        logic [3:0] tx;
        logic [3:0] ty;
        logic [2:0] yo;
    } slice_t;

    logic [31:0] tmem [0:4095];
    logic [11:0] mb [0:1][0:LW-1];
    int          mwb = 0;
    int          total = 0;
    int          bad = 0;
    int          en_cnt = 0;
    logic [11:0] last_addr = '0;

    // Tile pattern memory: one-cycle read latency.
    always @(posedge clk) begin
        if (tile_en) begin
            tile_data <= tmem[tile_addr];
            en_cnt    <= en_cnt + 1;
            last_addr <= tile_addr;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic slice_t mk(input int addr, input int f, input int l, input int flip,
                                  input int sx, input int z, input int pal, input int tbl,
                                  input int tx, input int ty, input int yo);
        slice_t s;
        s.addr = 10'(addr); s.first = 3'(f); s.last = 3'(l); s.flip = 1'(flip);
        s.sx = 3'(sx); s.z = 2'(z); s.pal = 5'(pal); s.tbl = 1'(tbl);
        s.tx = 4'(tx); s.ty = 4'(ty); s.yo = 3'(yo);
        return s;
    endfunction

    function automatic logic [11:0] taddr(input slice_t s, input int col);
        return {s.tbl, s.ty, 4'(col & 15), s.yo};
    endfunction

    task automatic drive(input slice_t s);
        line_addr = s.addr; first = s.first; last = s.last; hFlip = s.flip; sizeX = s.sx;
        line_z = s.z; line_palette = s.pal; tile_table = s.tbl; tile_x = s.tx;
        tile_y_total = s.ty; tile_y_offset = s.yo;
    endtask

    // Reference compositing; npix < 0 means the whole slice, otherwise stop after npix pixels.
    task automatic model_slice(input slice_t s, input int npix);
        int n = 0;
        for (int c = int'(s.first); c <= int'(s.last); c++) begin
            int col;
            logic [31:0] d;
            col = s.flip ? (int'(s.tx) + int'(s.sx) - c) : (int'(s.tx) + c);
            d = tmem[taddr(s, col)];
            for (int p = 0; p < 8; p++) begin
                int x;
                int sp;
                logic [3:0] idx;
                logic [11:0] e;
                if (npix >= 0 && n >= npix) return;
                n++;
                x = int'(s.addr) + 8 * c + p;
                sp = s.flip ? 7 - p : p;
                idx = d[4*sp +: 4];
                if (idx != 4'd0 && x < LW) begin
                    e = mb[mwb][x];
                    if (!e[11] || (ZPRIO && s.z > e[10:9]))
                        mb[mwb][x] = {1'b1, s.z, s.pal, idx};
                end
            end
        end
    endtask

    task automatic load_wait(input slice_t s, output int b);
        drive(s);
        line_load = 1'b1;
        tick();
        line_load = 1'b0;
        model_slice(s, -1);
        b = 0;
        while (line_busy && b < 300) begin
            b++;
            tick();
        end
    endtask

    task automatic swap();
        scanline_start = 1'b1;
        tick();
        scanline_start = 1'b0;
        mwb = 1 - mwb;
    endtask

    task automatic rd(input int x, input string tag);
        logic [11:0] e;
        pixel_x = 10'(x);
        pixel_read = 1'b1;
        tick();
        pixel_read = 1'b0;
        if (x < LW) begin
            e = mb[1-mwb][x];
            mb[1-mwb][x] = '0;
        end else begin
            e = '0;
        end
        chk({tag, "_color"}, 32'(pixel_color), 32'(e[8:0]));
        chk({tag, "_z"}, 32'(pixel_z), 32'(e[10:9]));
        chk({tag, "_valid"}, 32'(pixel_valid), 32'(e[11]));
    endtask

    initial begin
        slice_t s;
        slice_t s2;
        int b;
        int e0;

        for (int i = 0; i < 4096; i++) begin
            logic [31:0] w;
            w = $urandom;
            for (int k = 0; k < 8; k++)
                if ($urandom_range(0, 3) == 0) w[4*k +: 4] = 4'd0;
            tmem[i] = w;
        end
        for (int bk = 0; bk < 2; bk++)
            for (int i = 0; i < LW; i++)
                mb[bk][i] = '0;

        // Reset state
        tick(); tick();
        chk("rst_busy", 32'(line_busy), 32'd0);
        chk("rst_tile_en", 32'(tile_en), 32'd0);
        chk("rst_tile_addr", 32'(tile_addr), 32'd0);
        rst = 1'b0;
        tick();
        chk("rst_color", 32'(pixel_color), 32'd0);
        chk("rst_z", 32'(pixel_z), 32'd0);
        chk("rst_valid", 32'(pixel_valid), 32'd0);

        // Basic slice, no flip
        s = mk(100, 0, 0, 0, 0, 1, 3, 1, 5, 9, 2);
        tmem[taddr(s, 5)] = 32'h87654321;
        load_wait(s, b);
        chk("a_busy_len", 32'(b), 32'd10);
        chk("a_tile_addr", 32'(last_addr), 32'({1'b1, 4'd9, 4'd5, 3'd2}));
        swap();
        for (int i = 0; i < 8; i++) begin
            rd(100 + i, "a_rd");
            chk("a_const_color", 32'(pixel_color), 32'({5'd3, 4'(i + 1)}));
            chk("a_const_valid", 32'(pixel_valid), 32'd1);
        end

        // Flipped slice with sizeX=1
        s = mk(100, 0, 0, 1, 1, 1, 3, 1, 5, 3, 2);
        tmem[taddr(s, 5)] = 32'h11111111;
        tmem[taddr(s, 6)] = 32'h87654321;
        load_wait(s, b);
        chk("b_busy_len", 32'(b), 32'd10);
        chk("b_tile_addr", 32'(last_addr), 32'({1'b1, 4'd3, 4'd6, 3'd2}));
        swap();
        for (int i = 0; i < 8; i++) begin
            rd(100 + i, "b_rd");
            if (i == 0) chk("b_x100", 32'(pixel_color), 32'({5'd3, 4'd8}));
            if (i == 7) chk("b_x107", 32'(pixel_color), 32'({5'd3, 4'd1}));
        end

        // Right-edge clipping
        s = mk(636, 0, 1, 0, 1, 2, 4, 0, 0, 7, 0);
        tmem[taddr(s, 0)] = 32'h00000010;
        tmem[taddr(s, 1)] = 32'h00000010;
        e0 = en_cnt;
        load_wait(s, b);
        chk("edge_busy_len", 32'(b), 32'd20);
        chk("edge_fetches", 32'(en_cnt - e0), 32'd2);
        swap();
        for (int x = 636; x < 640; x++) begin
            rd(x, "edge_rd");
            chk("edge_opaque", 32'(pixel_valid), 32'(x == 637));
        end
        rd(640, "edge_rd640");
        rd(1023, "edge_rd1023");

        // Z priority and equal-z
        s = mk(300, 0, 0, 0, 0, 1, 5, 0, 2, 1, 0);
        tmem[taddr(s, 2)] = 32'h11111111;
        load_wait(s, b);
        s = mk(300, 0, 0, 0, 0, 2, 6, 0, 3, 1, 0);
        tmem[taddr(s, 3)] = 32'h22222222;
        load_wait(s, b);
        s = mk(400, 0, 0, 0, 0, 2, 7, 0, 2, 1, 0);
        load_wait(s, b);
        s = mk(400, 0, 0, 0, 0, 2, 8, 0, 3, 1, 0);
        load_wait(s, b);
        swap();
        for (int i = 0; i < 8; i++) begin
            rd(300 + i, "z_rd");
            chk("z_color", 32'(pixel_color), ZPRIO ? 32'({5'd6, 4'd2}) : 32'({5'd5, 4'd1}));
            chk("z_z", 32'(pixel_z), ZPRIO ? 32'd2 : 32'd1);
        end
        for (int i = 0; i < 8; i++) begin
            rd(400 + i, "zeq_rd");
            chk("zeq_color", 32'(pixel_color), 32'({5'd7, 4'd1}));
        end

        // Read clears the entry
        s = mk(48, 0, 0, 0, 0, 0, 1, 0, 8, 2, 1);
        tmem[taddr(s, 8)] = 32'h11111111;
        load_wait(s, b);
        swap();
        rd(50, "clr_rd1");
        chk("clr_first_valid", 32'(pixel_valid), 32'd1);
        rd(50, "clr_rd2");
        chk("clr_second_valid", 32'(pixel_valid), 32'd0);
        chk("clr_second_color", 32'(pixel_color), 32'd0);

        // Abort during DRAW at p=1
        s = mk(200, 0, 0, 0, 0, 1, 2, 0, 9, 2, 3);
        tmem[taddr(s, 9)] = 32'h9ABCDEF1;
        drive(s);
        line_load = 1'b1;
        tick();
        line_load = 1'b0;
        tick(); tick(); tick();
        chk("abort_busy_before", 32'(line_busy), 32'd1);
        model_slice(s, 2);
        swap();
        chk("abort_busy_after", 32'(line_busy), 32'd0);
        tick();
        chk("abort_busy_stays", 32'(line_busy), 32'd0);
        for (int i = 0; i < 8; i++) begin
            rd(200 + i, "abort_rd");
            chk("abort_valid", 32'(pixel_valid), 32'(i < 2));
        end

        // Load while busy is ignored
        s  = mk(500, 0, 0, 0, 0, 1, 9, 1, 1, 5, 4);
        s2 = mk(520, 0, 2, 0, 0, 3, 10, 1, 7, 6, 5);
        e0 = en_cnt;
        drive(s);
        line_load = 1'b1;
        tick();
        line_load = 1'b0;
        model_slice(s, -1);
        b = 0;
        while (line_busy && b < 300) begin
            b++;
            if (b == 3) begin
                drive(s2);
                line_load = 1'b1;
            end else begin
                line_load = 1'b0;
            end
            tick();
        end
        line_load = 1'b0;
        tick(); tick();
        chk("lwb_busy_len", 32'(b), 32'd10);
        chk("lwb_fetches", 32'(en_cnt - e0), 32'd1);
        chk("lwb_idle", 32'(line_busy), 32'd0);
        swap();
        for (int x = 500; x < 528; x++) rd(x, "lwb_rd");

        // Swap and load in the same cycle: load ignored
        s = mk(10, 0, 3, 0, 3, 1, 2, 0, 0, 0, 0);
        e0 = en_cnt;
        drive(s);
        line_load = 1'b1;
        scanline_start = 1'b1;
        tick();
        line_load = 1'b0;
        scanline_start = 1'b0;
        mwb = 1 - mwb;
        chk("same_busy", 32'(line_busy), 32'd0);
        tick();
        chk("same_fetches", 32'(en_cnt - e0), 32'd0);

        // first > last never goes busy
        s = mk(20, 5, 2, 0, 7, 1, 2, 0, 0, 0, 0);
        e0 = en_cnt;
        drive(s);
        line_load = 1'b1;
        tick();
        line_load = 1'b0;
        chk("empty_busy", 32'(line_busy), 32'd0);
        tick(); tick();
        chk("empty_busy_later", 32'(line_busy), 32'd0);
        chk("empty_fetches", 32'(en_cnt - e0), 32'd0);

        // Random slices composited and read back over the full line
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 4; k++) begin
                int f;
                int l;
                f = $urandom_range(0, 7);
                l = $urandom_range(f, 7);
                s = mk($urandom_range(0, 1023), f, l, $urandom_range(0, 1), $urandom_range(0, 7),
                       $urandom_range(0, 3), $urandom_range(0, 31), $urandom_range(0, 1),
                       $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 7));
                load_wait(s, b);
                chk("rnd_busy_len", 32'(b), 32'(10 * (l - f + 1)));
            end
            swap();
            for (int x = 0; x < LW; x++) rd(x, "rnd_rd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
